enc_dec_apb_master: RTL and testbench

//  APB initiator that programs and reads the enc_dec register file (ctrl/data_in/codeword_width/noise).

---
 rtl/enc_dec_apb_master.sv | 145 ++++++++++++++
 tb/tb_enc_dec_apb_master.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_dec_apb_master.sv
// APB initiator for the enc_dec register file: takes one read/write command at a time
// and runs it through SETUP/ACCESS with wait-state support and a bounded-wait abort.
module enc_dec_apb_master #(
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int AMBA_WORD       = 32,
  parameter int TIMEOUT_CYCLES  = 16,
  parameter int RD_SAMPLE_SETUP = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic                       rsp_valid,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [AMBA_ADDR_WIDTH-1:0] paddr,
  output logic [AMBA_WORD-1:0]       pwdata,
  output logic                       pwrite,
  output logic                       psel,
  output logic                       penable,
  input  logic [AMBA_WORD-1:0]       prdata,
  input  logic                       pready
);

  // Handshake: a command transfers on a posedge where cmd_valid & cmd_ready; cmd_ready is high
  // only in IDLE, nothing is queued. rsp_valid is a one-cycle pulse with no backpressure.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

  state_t                     state_q, state_d;
  logic [CW-1:0]              wait_cnt_q, wait_cnt_d;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
  logic                       pwrite_q, pwrite_d;
  logic                       psel_q, psel_d;
  logic                       penable_q, penable_d;
  logic [AMBA_WORD-1:0]       rd_cap_q, rd_cap_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic                       rsp_err_q, rsp_err_d;
  logic [AMBA_WORD-1:0]       rsp_rdata_q, rsp_rdata_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rd_cap_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rd_cap_q    <= rd_cap_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rd_cap_d    = rd_cap_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d    = SETUP;
          wait_cnt_d = '0;
          paddr_d    = cmd_addr;
          pwdata_d   = cmd_wdata;
          pwrite_d   = cmd_write;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        // The enc_dec register file presents read data already during SETUP.
        if ((RD_SAMPLE_SETUP != 0) && !pwrite_q) rd_cap_d = prdata;
      end
      ACCESS: begin
        if (pready) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          if (pwrite_q)                  rsp_rdata_d = '0;
          else if (RD_SAMPLE_SETUP != 0) rsp_rdata_d = rd_cap_q;
          else                           rsp_rdata_d = prdata;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_enc_dec_apb_master.sv
// Bench for enc_dec_apb_master: APB slave with programmable wait states plus a
// transaction-level reference memory and expected-response queue.
module tb_enc_dec_apb_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready;

  enc_dec_apb_master #(
    .AMBA_ADDR_WIDTH(32), .AMBA_WORD(32), .TIMEOUT_CYCLES(TO), .RD_SAMPLE_SETUP(1)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready)
  );

  // clock / reset
  always #5 clk = ~clk;

  // APB slave: pready rises after wait_n ACCESS cycles with pready low
  logic [31:0] slv_mem [0:63];
  int          wait_n   = 0;
  int          acc_cnt  = 0;
  bit          mem_init = 1'b0;

  assign pready = (acc_cnt >= wait_n);
  assign prdata = psel ? slv_mem[paddr[7:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) slv_mem[i] <= 32'h0;
    end else if (psel && penable && pready && pwrite) begin
      slv_mem[paddr[7:2]] <= pwdata;
    end
    if (!psel) acc_cnt <= 0;
    else if (penable && !pready) acc_cnt <= acc_cnt + 1;
  end

  // reference model and scoreboard
  logic [31:0] ref_mem [0:63];
  logic [32:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic void model_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                                    input int waits);
    logic        err;
    logic [31:0] rd;
    err = (waits >= TO);
    rd  = 32'h0;
    if (!err && w)  ref_mem[a[7:2]] = d;
    if (!err && !w) rd = ref_mem[a[7:2]];
    exp_q.push_back({err, rd});
  endfunction

  function automatic int model_pen(input int waits);
    return (waits >= TO) ? TO : waits + 1;
  endfunction

  // driver: issue one command, observe the transfer up to and one cycle past rsp_valid
  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits,
                         output int psel_n, output int pen_n, output int lat,
                         output logic [31:0] rdata, output logic err,
                         output bit stable, output bit rsp_one, output bit done);
    bit acc;
    acc = 1'b0;
    psel_n = 0; pen_n = 0; lat = 0; rdata = 32'h0; err = 1'b0;
    stable = 1'b1; rsp_one = 1'b0; done = 1'b0;
    @(negedge clk);
    wait_n = waits;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (cmd_ready) acc = 1'b1;
      @(negedge clk);
    end
    if (!acc) begin
      cmd_valid = 1'b0;
      return;
    end
    cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = $urandom; cmd_wdata = $urandom;
    for (int i = 0; i < 100; i++) begin
      if (psel) psel_n++;
      if (penable) pen_n++;
      if (rsp_valid) begin
        rdata = rsp_rdata; err = rsp_err; done = 1'b1; lat = i;
        break;
      end
      if (psel && (paddr !== a || pwdata !== d || pwrite !== w)) stable = 1'b0;
      @(negedge clk);
    end
    if (done) begin
      @(negedge clk);
      rsp_one = !rsp_valid && !rsp_err;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
    mem_init = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    n_cmp++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, busy, cmd_ready} !== 7'b0000001) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0000001",
               {psel, penable, pwrite, rsp_valid, rsp_err, busy, cmd_ready});
    end
    n_cmp++;
    if (paddr !== 32'h0) begin n_bad++; $display("FAIL reset_paddr: got %h want 0", paddr); end
    n_cmp++;
    if (pwdata !== 32'h0) begin n_bad++; $display("FAIL reset_pwdata: got %h want 0", pwdata); end
    n_cmp++;
    if (rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write;
    int psel_n, pen_n, lat; logic [31:0] rdata; logic err; bit stable, rsp_one, done;
    logic [32:0] exp;
    model_cmd(1'b1, 32'h0, 32'h0000_0001, 0);
    run_cmd(1'b1, 32'h0, 32'h0000_0001, 0, psel_n, pen_n, lat, rdata, err, stable, rsp_one, done);
    exp = exp_q.pop_front();
    n_cmp++; if (!done) begin n_bad++; $display("FAIL single_done: got no response want one"); end
    n_cmp++; if (psel_n !== 2) begin n_bad++; $display("FAIL single_psel: got %0d want 2", psel_n); end
    n_cmp++; if (pen_n !== 1) begin n_bad++; $display("FAIL single_penable: got %0d want 1", pen_n); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL single_latency: got %0d want 2", lat); end
    n_cmp++;
    if ({err, rdata} !== exp) begin n_bad++; $display("FAIL single_rsp: got %h want %h", {err, rdata}, exp); end
    n_cmp++; if (!stable) begin n_bad++; $display("FAIL single_stable: got 0 want 1"); end
    n_cmp++; if (!rsp_one) begin n_bad++; $display("FAIL single_pulse: got 0 want 1"); end
  endtask

  task automatic test_write_read;
    int psel_n, pen_n, lat; logic [31:0] rdata; logic err; bit stable, rsp_one, done;
    logic [32:0] exp;
    logic [31:0] a_l [0:2];
    logic [31:0] d_l [0:2];
    a_l = '{32'h4, 32'h8, 32'hC};
    d_l = '{32'hA5A5_0F0F, 32'h0000_0020, 32'h0000_0003};
    for (int k = 0; k < 6; k++) begin
      logic w;
      logic [31:0] d;
      w = (k < 3);
      d = w ? d_l[k % 3] : $urandom;
      model_cmd(w, a_l[k % 3], d, 0);
      run_cmd(w, a_l[k % 3], d, 0, psel_n, pen_n, lat, rdata, err, stable, rsp_one, done);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!done || {err, rdata} !== exp) begin
        n_bad++; $display("FAIL wr_rd_rsp[%0d]: got %h done %0d want %h", k, {err, rdata}, done, exp);
      end
      n_cmp++;
      if (!stable || !rsp_one || lat !== 2) begin
        n_bad++; $display("FAIL wr_rd_timing[%0d]: got stable %0d pulse %0d lat %0d want 1 1 2",
                          k, stable, rsp_one, lat);
      end
    end
  endtask

  task automatic test_wait_states;
    int psel_n, pen_n, lat; logic [31:0] rdata; logic err; bit stable, rsp_one, done;
    logic [32:0] exp;
    int waits_l [0:2];
    waits_l = '{3, TO - 1, 1};
    for (int k = 0; k < 3; k++) begin
      logic [31:0] d;
      d = $urandom;
      model_cmd(1'b1, 32'h10, d, waits_l[k]);
      run_cmd(1'b1, 32'h10, d, waits_l[k], psel_n, pen_n, lat, rdata, err, stable, rsp_one, done);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!done || {err, rdata} !== exp) begin
        n_bad++; $display("FAIL wait_rsp[%0d]: got %h done %0d want %h", k, {err, rdata}, done, exp);
      end
      n_cmp++;
      if (pen_n !== waits_l[k] + 1) begin
        n_bad++; $display("FAIL wait_penable[%0d]: got %0d want %0d", k, pen_n, waits_l[k] + 1);
      end
      n_cmp++;
      if (!stable || psel_n !== waits_l[k] + 2) begin
        n_bad++; $display("FAIL wait_psel[%0d]: got %0d stable %0d want %0d stable 1",
                          k, psel_n, stable, waits_l[k] + 2);
      end
    end
  endtask

  task automatic test_timeout;
    int psel_n, pen_n, lat; logic [31:0] rdata; logic err; bit stable, rsp_one, done;
    logic [32:0] exp;
    logic w_l [0:2];
    logic [31:0] a_l [0:2];
    int waits_l [0:2];
    w_l = '{1'b0, 1'b1, 1'b0};
    a_l = '{32'h8, 32'hC, 32'hC};
    waits_l = '{1000, TO, 0};
    for (int k = 0; k < 3; k++) begin
      logic [31:0] d;
      d = $urandom;
      model_cmd(w_l[k], a_l[k], d, waits_l[k]);
      run_cmd(w_l[k], a_l[k], d, waits_l[k], psel_n, pen_n, lat, rdata, err, stable, rsp_one, done);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!done || {err, rdata} !== exp) begin
        n_bad++; $display("FAIL timeout_rsp[%0d]: got %h done %0d want %h", k, {err, rdata}, done, exp);
      end
      n_cmp++;
      if (pen_n !== model_pen(waits_l[k]) || lat !== model_pen(waits_l[k]) + 1) begin
        n_bad++; $display("FAIL timeout_len[%0d]: got penable %0d lat %0d want %0d %0d", k, pen_n, lat,
                          model_pen(waits_l[k]), model_pen(waits_l[k]) + 1);
      end
      n_cmp++;
      if (!rsp_one) begin n_bad++; $display("FAIL timeout_pulse[%0d]: got 0 want 1", k); end
    end
  endtask

  task automatic test_reset_mid;
    int psel_n, pen_n, lat; logic [31:0] rdata; logic err; bit stable, rsp_one, done;
    logic [32:0] exp;
    bit in_access;
    int rsp_n;
    in_access = 1'b0; rsp_n = 0;
    @(negedge clk);
    wait_n = 1000;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4; cmd_wdata = 32'h1234_5678;
    for (int i = 0; i < 40 && !in_access; i++) begin
      @(negedge clk);
      if (!cmd_ready) cmd_valid = 1'b0;
      if (penable) in_access = 1'b1;
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if (!in_access || {psel, penable, busy} !== 3'b000) begin
      n_bad++; $display("FAIL reset_async: got psel/penable/busy %b access %0d want 000 1",
                        {psel, penable, busy}, in_access);
    end
    repeat (3) begin @(negedge clk); if (rsp_valid) rsp_n++; end
    rstn = 1'b1;
    repeat (3) begin @(negedge clk); if (rsp_valid) rsp_n++; end
    n_cmp++;
    if (rsp_n !== 0) begin n_bad++; $display("FAIL reset_no_rsp: got %0d want 0", rsp_n); end
    model_cmd(1'b0, 32'h4, 32'h0, 0);
    run_cmd(1'b0, 32'h4, 32'h0, 0, psel_n, pen_n, lat, rdata, err, stable, rsp_one, done);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!done || {err, rdata} !== exp || lat !== 2) begin
      n_bad++; $display("FAIL reset_recover: got %h done %0d lat %0d want %h lat 2",
                        {err, rdata}, done, lat, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic        w_l [0:3];
    logic [31:0] a_l [0:3];
    logic [31:0] d_l [0:3];
    logic [32:0] exp;
    int idx, rsp_seen, last_acc;
    w_l = '{1'b1, 1'b0, 1'b1, 1'b0};
    a_l = '{32'h20, 32'h20, 32'h24, 32'h24};
    for (int k = 0; k < 4; k++) d_l[k] = $urandom;
    idx = 0; rsp_seen = 0; last_acc = -1;
    @(negedge clk);
    wait_n = 0;
    cmd_valid = 1'b1; cmd_write = w_l[0]; cmd_addr = a_l[0]; cmd_wdata = d_l[0];
    for (int cyc = 0; cyc < 80 && !(idx == 4 && rsp_seen == 4); cyc++) begin
      if (rsp_valid) begin
        rsp_seen++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL b2b_rsp: got unexpected response %h want none", {rsp_err, rsp_rdata});
        end else begin
          exp = exp_q.pop_front();
          if ({rsp_err, rsp_rdata} !== exp) begin
            n_bad++; $display("FAIL b2b_rsp[%0d]: got %h want %h", rsp_seen - 1, {rsp_err, rsp_rdata}, exp);
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        model_cmd(w_l[idx], a_l[idx], d_l[idx], 0);
        if (idx > 0) begin
          n_cmp++;
          if (cyc - last_acc !== 3) begin
            n_bad++; $display("FAIL b2b_spacing[%0d]: got %0d want 3", idx, cyc - last_acc);
          end
        end
        last_acc = cyc;
        idx++;
        @(posedge clk);
        #1;
        if (idx < 4) begin
          cmd_write = w_l[idx]; cmd_addr = a_l[idx]; cmd_wdata = d_l[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    n_cmp++;
    if (idx !== 4 || rsp_seen !== 4) begin
      n_bad++; $display("FAIL b2b_count: got accepts %0d responses %0d want 4 4", idx, rsp_seen);
    end
    exp_q.delete();
  endtask

  task automatic test_random;
    int psel_n, pen_n, lat; logic [31:0] rdata; logic err; bit stable, rsp_one, done;
    logic [32:0] exp;
    for (int k = 0; k < 24; k++) begin
      logic        w;
      logic [31:0] a, d;
      int          waits;
      w = 1'($urandom_range(0, 1));
      a = {24'h0, 3'($urandom_range(0, 7)), 5'b0} + 32'h40;
      d = $urandom;
      waits = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 4);
      model_cmd(w, a, d, waits);
      run_cmd(w, a, d, waits, psel_n, pen_n, lat, rdata, err, stable, rsp_one, done);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!done || {err, rdata} !== exp) begin
        n_bad++; $display("FAIL rand_rsp[%0d]: got %h done %0d want %h", k, {err, rdata}, done, exp);
      end
      n_cmp++;
      if (pen_n !== model_pen(waits) || psel_n !== model_pen(waits) + 1 || !stable || !rsp_one) begin
        n_bad++; $display("FAIL rand_shape[%0d]: got penable %0d psel %0d stable %0d pulse %0d want %0d %0d 1 1",
                          k, pen_n, psel_n, stable, rsp_one, model_pen(waits), model_pen(waits) + 1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_write_read();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
